// File: rtl/axi_stream_pin_capture.sv
// axi_stream_pin_capture: strobed pin sampler that packs beats into words, buffers them in a FIFO
// and emits runtime-length AXI4-Stream packets, counting dropped words instead of stalling the pins.
module axi_stream_pin_capture #(
    parameter int PIN_W           = 8,
    parameter int DATA_W          = 32,
    parameter int FIFO_DEPTH_BITS = 4,
    parameter int PKT_W           = 18,
    parameter int DROP_W          = 16
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       enable,
    input  logic                       pins_valid,
    input  logic [PIN_W-1:0]           data_pins,
    input  logic [PKT_W-1:0]           pkt_words,
    input  logic                       clr_stats,
    output logic                       m_axis_tvalid,
    output logic [DATA_W-1:0]          m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic [DATA_W/8-1:0]        m_axis_tkeep,
    input  logic                       m_axis_tready,
    output logic [FIFO_DEPTH_BITS:0]   fifo_level,
    output logic [DROP_W-1:0]          drop_count,
    output logic                       overflow
);
    localparam int BEATS = DATA_W / PIN_W;
    localparam int BCW   = $clog2(BEATS);
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;

    logic [BCW-1:0]             beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0]          acc_q, acc_d, word;
    logic [DATA_W-1:0]          fifo_mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_BITS:0]   level_q, level_d;
    logic [DROP_W-1:0]          drop_q, drop_d;
    logic                       ovf_q, ovf_d, tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [DATA_W-1:0]          tdata_q, tdata_d;
    logic [PKT_W-1:0]           word_cnt_q, word_cnt_d, pkt_len_q, pkt_len_d, len_eff;
    logic                       sample, word_done, empty, full, rd, wr, drop;

    always_comb begin
        sample    = enable && pins_valid;
        word_done = sample && (beat_cnt_q == BCW'(BEATS - 1));
        word      = acc_q;
        word[beat_cnt_q*PIN_W +: PIN_W] = data_pins;
        acc_d      = sample ? word : acc_q;
        beat_cnt_d = !enable ? '0 : sample ? (word_done ? '0 : beat_cnt_q + 1'b1) : beat_cnt_q;
        empty = level_q == 0;
        full  = level_q[FIFO_DEPTH_BITS];
        rd    = (!tvalid_q || m_axis_tready) && !empty;
        // a read in the same cycle frees a slot, so a full FIFO can still accept
        wr    = word_done && (!full || rd);
        drop  = word_done && !wr;
        wr_ptr_d = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = (wr && !rd) ? level_q + 1'b1 : (rd && !wr) ? level_q - 1'b1 : level_q;
        drop_d   = clr_stats ? '0 : (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
        ovf_d    = !clr_stats && (ovf_q || drop);
        // the first load of a packet samples pkt_words live; later loads use the latched copy
        len_eff    = (word_cnt_q == 0) ? pkt_words : pkt_len_q;
        pkt_len_d  = rd ? len_eff : pkt_len_q;
        tlast_d    = rd ? (word_cnt_q == len_eff - 1'b1) : tlast_q;
        word_cnt_d = rd ? (tlast_d ? '0 : word_cnt_q + 1'b1) : word_cnt_q;
        tdata_d    = rd ? fifo_mem[rd_ptr_q] : tdata_q;
        tvalid_d   = rd || (tvalid_q && !m_axis_tready);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            beat_cnt_q <= '0;
            acc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_q     <= '0;
            ovf_q      <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
            word_cnt_q <= '0;
            pkt_len_q  <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            acc_q      <= acc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_q     <= drop_d;
            ovf_q      <= ovf_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tdata_q    <= tdata_d;
            word_cnt_q <= word_cnt_d;
            pkt_len_q  <= pkt_len_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (wr) fifo_mem[wr_ptr_q] <= word;
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tkeep  = '1;
    assign fifo_level    = level_q;
    assign drop_count    = drop_q;
    assign overflow      = ovf_q;
endmodule
